// File: rtl/lsu_stbuf_queue.sv
// Committed-store buffer feeding the DCCM/PIC write port.
// Coalesces into the youngest entry and forwards merged bytes to loads.
module lsu_stbuf_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_vld,
  input  logic [ADDR_W-1:0]   enq_addr,
  input  logic                enq_in_pic,
  input  logic [DATA_W/8-1:0] enq_byteen,
  input  logic [DATA_W-1:0]   enq_data,
  output logic                stbuf_reqvld_any,
  output logic [ADDR_W-1:0]   stbuf_addr_any,
  output logic                stbuf_addr_in_pic_any,
  output logic [DATA_W/8-1:0] stbuf_byteen_any,
  output logic [DATA_W-1:0]   stbuf_data_any,
  input  logic                lsu_stbuf_commit_any,
  input  logic                ld_vld_dc2,
  input  logic [ADDR_W-1:0]   ld_addr_lo_dc2,
  input  logic [ADDR_W-1:0]   ld_addr_hi_dc2,
  output logic [DATA_W-1:0]   stbuf_fwddata_lo_dc3,
  output logic [DATA_W-1:0]   stbuf_fwddata_hi_dc3,
  output logic [DATA_W/8-1:0] stbuf_fwdbyteen_lo_dc3,
  output logic [DATA_W/8-1:0] stbuf_fwdbyteen_hi_dc3,
  output logic                stbuf_full,
  output logic                stbuf_empty,
  output logic                stbuf_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;
  localparam int WA = ADDR_W - 2;

  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  pic_q;
  logic [WA-1:0]     addr_q [DEPTH];
  logic [NB-1:0]     be_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] yng, idx;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          reqvld, drain, coal, alloc;
  logic [WA-1:0] enq_wa, ld_lo_wa, ld_hi_wa;
  logic [DATA_W-1:0] merged;

  logic [DATA_W-1:0] fwd_lo_d, fwd_lo_q, fwd_hi_d, fwd_hi_q;
  logic [NB-1:0]     fbe_lo_d, fbe_lo_q, fbe_hi_d, fbe_hi_q;

  logic unused_lo_bits;
  assign unused_lo_bits = ^{enq_addr[1:0], ld_addr_lo_dc2[1:0],
                            ld_addr_hi_dc2[1:0]};

  assign enq_wa   = enq_addr[ADDR_W-1:2];
  assign ld_lo_wa = ld_addr_lo_dc2[ADDR_W-1:2];
  assign ld_hi_wa = ld_addr_hi_dc2[ADDR_W-1:2];
  assign yng      = wr_ptr_q - PW'(1);

  assign stbuf_full  = (cnt_q == (PW+1)'(DEPTH));
  assign stbuf_empty = (cnt_q == '0);
  assign stbuf_overflow = ovf_q;

  assign reqvld = vld_q[rd_ptr_q];
  assign stbuf_reqvld_any = reqvld;
  assign stbuf_addr_any = reqvld ? {addr_q[rd_ptr_q], 2'b00} : '0;
  assign stbuf_addr_in_pic_any = reqvld & pic_q[rd_ptr_q];
  assign stbuf_byteen_any = reqvld ? be_q[rd_ptr_q] : '0;
  assign stbuf_data_any = reqvld ? data_q[rd_ptr_q] : '0;

  always_comb begin
    drain = lsu_stbuf_commit_any & reqvld;
    // Never merge into an entry that is leaving this cycle.
    coal = enq_vld & vld_q[yng] & (addr_q[yng] == enq_wa)
         & (pic_q[yng] == enq_in_pic)
         & ~(drain & (yng == rd_ptr_q));
    alloc = enq_vld & ~coal & (~stbuf_full | drain);
    wr_ptr_d = alloc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = drain ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d = cnt_q;
    unique case ({alloc, drain})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q | (enq_vld & ~coal & stbuf_full & ~drain);
    for (int b = 0; b < NB; b++)
      merged[b*8 +: 8] = enq_byteen[b] ? enq_data[b*8 +: 8]
                                       : data_q[yng][b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      if (drain) vld_q[rd_ptr_q] <= 1'b0;
      // Full+commit: freed slot equals wr_ptr, so allocate wins.
      if (alloc) vld_q[wr_ptr_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[wr_ptr_q] <= enq_wa;
      pic_q[wr_ptr_q]  <= enq_in_pic;
      be_q[wr_ptr_q]   <= enq_byteen;
      data_q[wr_ptr_q] <= enq_data;
    end else if (coal) begin
      be_q[yng]   <= be_q[yng] | enq_byteen;
      data_q[yng] <= merged;
    end
  end

  // Walk oldest to youngest so younger entries override per byte.
  always_comb begin
    fwd_lo_d = '0;
    fwd_hi_d = '0;
    fbe_lo_d = '0;
    fbe_hi_d = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = wr_ptr_q + PW'(k);
      for (int b = 0; b < NB; b++) begin
        if (ld_vld_dc2 && vld_q[idx] && be_q[idx][b]) begin
          if (addr_q[idx] == ld_lo_wa) begin
            fwd_lo_d[b*8 +: 8] = data_q[idx][b*8 +: 8];
            fbe_lo_d[b] = 1'b1;
          end
          if (addr_q[idx] == ld_hi_wa) begin
            fwd_hi_d[b*8 +: 8] = data_q[idx][b*8 +: 8];
            fbe_hi_d[b] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_lo_q <= '0;
      fwd_hi_q <= '0;
      fbe_lo_q <= '0;
      fbe_hi_q <= '0;
    end else begin
      fwd_lo_q <= fwd_lo_d;
      fwd_hi_q <= fwd_hi_d;
      fbe_lo_q <= fbe_lo_d;
      fbe_hi_q <= fbe_hi_d;
    end
  end

  assign stbuf_fwddata_lo_dc3   = fwd_lo_q;
  assign stbuf_fwddata_hi_dc3   = fwd_hi_q;
  assign stbuf_fwdbyteen_lo_dc3 = fbe_lo_q;
  assign stbuf_fwdbyteen_hi_dc3 = fbe_hi_q;

endmodule

// File: tb/tb_lsu_stbuf_queue.sv
// Directed bench for lsu_stbuf_queue: drain, coalesce, full/overflow,
// forwarding priority, unaligned loads and mid-operation reset.
module tb_lsu_stbuf_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_vld;
  logic [15:0] enq_addr;
  logic        enq_in_pic;
  logic [3:0]  enq_byteen;
  logic [31:0] enq_data;
  logic        stbuf_reqvld_any;
  logic [15:0] stbuf_addr_any;
  logic        stbuf_addr_in_pic_any;
  logic [3:0]  stbuf_byteen_any;
  logic [31:0] stbuf_data_any;
  logic        lsu_stbuf_commit_any;
  logic        ld_vld_dc2;
  logic [15:0] ld_addr_lo_dc2;
  logic [15:0] ld_addr_hi_dc2;
  logic [31:0] stbuf_fwddata_lo_dc3;
  logic [31:0] stbuf_fwddata_hi_dc3;
  logic [3:0]  stbuf_fwdbyteen_lo_dc3;
  logic [3:0]  stbuf_fwdbyteen_hi_dc3;
  logic        stbuf_full;
  logic        stbuf_empty;
  logic        stbuf_overflow;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_stbuf_queue dut (
    .clk                    (clk),
    .rst                    (rst),
    .enq_vld                (enq_vld),
    .enq_addr               (enq_addr),
    .enq_in_pic             (enq_in_pic),
    .enq_byteen             (enq_byteen),
    .enq_data               (enq_data),
    .stbuf_reqvld_any       (stbuf_reqvld_any),
    .stbuf_addr_any         (stbuf_addr_any),
    .stbuf_addr_in_pic_any  (stbuf_addr_in_pic_any),
    .stbuf_byteen_any       (stbuf_byteen_any),
    .stbuf_data_any         (stbuf_data_any),
    .lsu_stbuf_commit_any   (lsu_stbuf_commit_any),
    .ld_vld_dc2             (ld_vld_dc2),
    .ld_addr_lo_dc2         (ld_addr_lo_dc2),
    .ld_addr_hi_dc2         (ld_addr_hi_dc2),
    .stbuf_fwddata_lo_dc3   (stbuf_fwddata_lo_dc3),
    .stbuf_fwddata_hi_dc3   (stbuf_fwddata_hi_dc3),
    .stbuf_fwdbyteen_lo_dc3 (stbuf_fwdbyteen_lo_dc3),
    .stbuf_fwdbyteen_hi_dc3 (stbuf_fwdbyteen_hi_dc3),
    .stbuf_full             (stbuf_full),
    .stbuf_empty            (stbuf_empty),
    .stbuf_overflow         (stbuf_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    enq_vld = 1'b0;
    enq_addr = '0;
    enq_in_pic = 1'b0;
    enq_byteen = '0;
    enq_data = '0;
    lsu_stbuf_commit_any = 1'b0;
    ld_vld_dc2 = 1'b0;
    ld_addr_lo_dc2 = '0;
    ld_addr_hi_dc2 = '0;
  endtask

  task automatic enq(input logic [15:0] a, input logic [3:0] be,
                     input logic [31:0] d);
    enq_vld = 1'b1;
    enq_addr = a;
    enq_byteen = be;
    enq_data = d;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic ld(input logic [15:0] lo, input logic [15:0] hi);
    ld_vld_dc2 = 1'b1;
    ld_addr_lo_dc2 = lo;
    ld_addr_hi_dc2 = hi;
  endtask

  initial begin
    do_reset();
    chk("rst_reqvld", 32'(stbuf_reqvld_any), 32'h0);
    chk("rst_empty", 32'(stbuf_empty), 32'h1);
    chk("rst_full", 32'(stbuf_full), 32'h0);
    chk("rst_ovf", 32'(stbuf_overflow), 32'h0);
    chk("rst_addr", 32'(stbuf_addr_any), 32'h0);
    chk("rst_fwdlo", stbuf_fwddata_lo_dc3, 32'h0);

    // single store, then drain
    enq(16'h0100, 4'hF, 32'hDEADBEEF);
    tick();
    idle();
    chk("s1_reqvld", 32'(stbuf_reqvld_any), 32'h1);
    chk("s1_addr", 32'(stbuf_addr_any), 32'h0100);
    chk("s1_data", stbuf_data_any, 32'hDEADBEEF);
    chk("s1_be", 32'(stbuf_byteen_any), 32'hF);
    chk("s1_empty", 32'(stbuf_empty), 32'h0);
    lsu_stbuf_commit_any = 1'b1;
    tick();
    idle();
    chk("s1_drain_reqvld", 32'(stbuf_reqvld_any), 32'h0);
    chk("s1_drain_empty", 32'(stbuf_empty), 32'h1);
    chk("s1_drain_data", stbuf_data_any, 32'h0);

    // coalesce
    enq(16'h0104, 4'h3, 32'h00001122);
    tick();
    enq(16'h0104, 4'hC, 32'h33440000);
    tick();
    idle();
    chk("s2_be", 32'(stbuf_byteen_any), 32'hF);
    chk("s2_data", stbuf_data_any, 32'h33441122);
    chk("s2_addr", 32'(stbuf_addr_any), 32'h0104);
    lsu_stbuf_commit_any = 1'b1;
    tick();
    idle();
    chk("s2_one_entry", 32'(stbuf_empty), 32'h1);

    // fill, overflow, full+commit
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      enq(16'(i * 16), 4'hF, 32'(i));
      tick();
    end
    idle();
    chk("s3_full", 32'(stbuf_full), 32'h1);
    chk("s3_head0", 32'(stbuf_addr_any), 32'h0010);
    enq(16'h0050, 4'hF, 32'h50);
    tick();
    idle();
    chk("s3_ovf", 32'(stbuf_overflow), 32'h1);
    chk("s3_ovf_full", 32'(stbuf_full), 32'h1);
    chk("s3_ovf_head", 32'(stbuf_addr_any), 32'h0010);
    enq(16'h0060, 4'hF, 32'h60);
    lsu_stbuf_commit_any = 1'b1;
    tick();
    idle();
    chk("s3_fc_full", 32'(stbuf_full), 32'h1);
    chk("s3_fc_head", 32'(stbuf_addr_any), 32'h0020);
    lsu_stbuf_commit_any = 1'b1;
    tick();
    chk("s3_d1_head", 32'(stbuf_addr_any), 32'h0030);
    chk("s3_d1_full", 32'(stbuf_full), 32'h0);
    tick();
    chk("s3_d2_head", 32'(stbuf_addr_any), 32'h0040);
    tick();
    chk("s3_d3_head", 32'(stbuf_addr_any), 32'h0060);
    chk("s3_d3_data", stbuf_data_any, 32'h60);
    tick();
    idle();
    chk("s3_d4_empty", 32'(stbuf_empty), 32'h1);
    chk("s3_ovf_sticky", 32'(stbuf_overflow), 32'h1);

    // forwarding priority, head drained during lookup
    do_reset();
    chk("s4_ovf_clr", 32'(stbuf_overflow), 32'h0);
    enq(16'h0200, 4'hF, 32'h11111111);
    tick();
    enq(16'h0300, 4'hF, 32'hCCCCCCCC);
    tick();
    enq(16'h0200, 4'h1, 32'h000000AA);
    tick();
    idle();
    ld(16'h0200, 16'h0200);
    lsu_stbuf_commit_any = 1'b1;
    enq(16'h0200, 4'h2, 32'h0000BB00);
    tick();
    idle();
    chk("s4_fwdlo", stbuf_fwddata_lo_dc3, 32'h111111AA);
    chk("s4_fbelo", 32'(stbuf_fwdbyteen_lo_dc3), 32'hF);
    chk("s4_fwdhi", stbuf_fwddata_hi_dc3, 32'h111111AA);
    chk("s4_fbehi", 32'(stbuf_fwdbyteen_hi_dc3), 32'hF);
    chk("s4_head", 32'(stbuf_addr_any), 32'h0300);
    tick();
    chk("s4_nold_be", 32'(stbuf_fwdbyteen_lo_dc3), 32'h0);
    chk("s4_nold_data", stbuf_fwddata_lo_dc3, 32'h0);
    ld(16'h0200, 16'h0200);
    tick();
    idle();
    chk("s4_merge_data", stbuf_fwddata_lo_dc3, 32'h0000BBAA);
    chk("s4_merge_be", 32'(stbuf_fwdbyteen_lo_dc3), 32'h3);

    // unaligned load
    do_reset();
    enq(16'h0304, 4'h1, 32'h00000055);
    tick();
    idle();
    ld(16'h0300, 16'h0304);
    tick();
    idle();
    chk("s5_fbelo", 32'(stbuf_fwdbyteen_lo_dc3), 32'h0);
    chk("s5_fwdlo", stbuf_fwddata_lo_dc3, 32'h0);
    chk("s5_fbehi", 32'(stbuf_fwdbyteen_hi_dc3), 32'h1);
    chk("s5_fwdhi", stbuf_fwddata_hi_dc3, 32'h00000055);

    // reset mid-operation
    do_reset();
    enq(16'h0400, 4'hF, 32'h01020304);
    tick();
    enq(16'h0404, 4'hF, 32'h05060708);
    tick();
    enq(16'h0408, 4'hF, 32'h090A0B0C);
    tick();
    idle();
    ld(16'h0404, 16'h0408);
    tick();
    chk("s6_fwdlo", stbuf_fwddata_lo_dc3, 32'h05060708);
    chk("s6_fwdhi", stbuf_fwddata_hi_dc3, 32'h090A0B0C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("s6_empty", 32'(stbuf_empty), 32'h1);
    chk("s6_reqvld", 32'(stbuf_reqvld_any), 32'h0);
    chk("s6_full", 32'(stbuf_full), 32'h0);
    chk("s6_fwdlo0", stbuf_fwddata_lo_dc3, 32'h0);
    chk("s6_fwdhi0", stbuf_fwddata_hi_dc3, 32'h0);
    chk("s6_fbe0", 32'({stbuf_fwdbyteen_lo_dc3, stbuf_fwdbyteen_hi_dc3}),
        32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_stbuf_queue.md
Name: lsu_stbuf_queue

Overview:
- Committed-store buffer that sits directly upstream of the DCCM/PIC port control.
- Accepts retired stores at commit and holds them in a small circular FIFO.
- Presents the oldest entry as the write request to the DCCM/PIC port and retires it when the port control grants it.
- Also supplies byte-merged forwarding data and byte enables to loads, one cycle after lookup, timed to land in DC3.

Parameters:
DEPTH, 4, number of entries (power of two, ≥2)
ADDR_W, 16, byte-address width of DCCM/PIC window
DATA_W, 32, entry data width (bytes = DATA_W/8 = 4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enq_vld  in  1  committed store to enqueue
enq_addr  in  ADDR_W  store byte address; bits [1:0] ignored (entry is word-keyed)
enq_in_pic  in  1  store targets PIC
enq_byteen  in  4  lane byte enables
enq_data  in  32  lane-aligned store data
stbuf_reqvld_any  out  1  head entry valid
stbuf_addr_any  out  ADDR_W  head word address, [1:0]=0
stbuf_addr_in_pic_any  out  1  head PIC flag
stbuf_byteen_any  out  4  head byte enables
stbuf_data_any  out  32  head data
lsu_stbuf_commit_any  in  1  grant: head is written this cycle
ld_vld_dc2  in  1  load lookup valid
ld_addr_lo_dc2  in  ADDR_W  load start address
ld_addr_hi_dc2  in  ADDR_W  load end address
stbuf_fwddata_lo_dc3  out  32  forwarded data, lo word
stbuf_fwddata_hi_dc3  out  32  forwarded data, hi word
stbuf_fwdbyteen_lo_dc3  out  4  forwarded byte mask, lo word
stbuf_fwdbyteen_hi_dc3  out  4  forwarded byte mask, hi word
stbuf_full  out  1  count==DEPTH
stbuf_empty  out  1  count==0
stbuf_overflow  out  1  sticky: enqueue dropped

Behaviour:
- State:
  - Per entry: vld, word addr, in_pic, byteen, data.
  - wr_ptr, rd_ptr: log2(DEPTH) bits, wrap modulo DEPTH.
  - count: log2(DEPTH)+1 bits.
- Reset: all vld=0, pointers=0, count=0, stbuf_overflow=0. All outputs 0 except stbuf_empty=1.
- Head outputs are combinational from entry[rd_ptr]. reqvld = vld[rd_ptr]. Head fields are forced to 0 when reqvld=0.
- Drain: commit_any & reqvld → clear vld[rd_ptr], rd_ptr+1. commit_any with reqvld=0 is ignored.
- Coalesce: applies when enq_vld, youngest entry (wr_ptr-1) is valid, word address equal, in_pic equal, and that entry is not being drained this cycle (it is not the head while commit_any=1).
  - Merge: byteen |= enq_byteen; data bytes with enq_byteen=1 are overwritten.
  - No pointer or count change.
- Allocate: enq_vld without coalesce → write entry[wr_ptr], vld=1, wr_ptr+1.
- Full boundary: full & enq & commit same cycle → allocation accepted into freed slot; count unchanged.
- Overflow: full & enq & no commit & no coalesce → store dropped, stbuf_overflow set to 1 until rst.
- count update: +1 on allocate only, −1 on drain only, unchanged on both/neither. full/empty are combinational from count.
- Forwarding:
  - Lookup in DC2 over entries valid at the start of the cycle. This includes the head being drained that cycle. It excludes a store enqueued the same cycle.
  - Per byte b of lo (hi): the youngest valid entry with word addr == ld_addr_lo[ADDR_W-1:2] (hi) and byteen[b]=1 supplies data byte b and sets mask bit b.
  - Youngest = nearest to wr_ptr going backward.
  - in_pic is not compared.
- Forward results are registered: DC3 outputs update every cycle. They are 0 when ld_vld_dc2=0 or on no match.
- Aligned loads: lo==hi word gives identical lo/hi outputs.
- Latency:
  - Enqueue → visible at head next cycle, when the queue is empty.
  - Lookup → result 1 cycle later.
- Reset mid-operation: all contents discarded. The DC3 forward registers clear on the cycle after rst.

Test Plan:
- Reset, then enq addr=0x0100 byteen=0xF data=0xDEADBEEF with commit low → next cycle reqvld=1, addr_any=0x0100, data_any=0xDEADBEEF, count=1; commit pulse → reqvld=0, empty=1.
- Back-to-back enq 0x0104 byteen=0x3 data=0x00001122, then 0x0104 byteen=0xC data=0x33440000 → single entry byteen=0xF data=0x33441122, count=1.
- Fill 4 distinct words with no commit → full=1; 5th enq without commit → dropped, overflow=1, count=4; 5th enq with commit → accepted, count stays 4, wr_ptr wraps to entry 1 and rd_ptr advances to entry 1.
- Entries (oldest→youngest) 0x0200 byteen=0xF data=0x11111111 and 0x0200 byteen=0x1 data=0x000000AA (head being drained) → load lo=hi=0x0200: DC3 fwddata_lo=0x111111AA, fwdbyteen_lo=0xF.
- Unaligned load lo=0x0300 hi=0x0304; entry 0x0304 byteen=0x1 data=0x55 → fwdbyteen_lo=0x0, fwdbyteen_hi=0x1, fwddata_hi=0x00000055.
- rst asserted with 3 valid entries and a lookup in flight → next cycle count=0, empty=1, reqvld=0, all fwd outputs 0.
